f32_decimal_formatter: RTL
==========================

Name: f32_decimal_formatter

Overview:
- Downstream display stage for the float32 adder-subtractor result (and operands A/B).
- Converts one IEEE-754 single into sign, integer BCD digits and fractional BCD digits, plus a special-case code, for the character LCD driver.
- Multi-cycle: unpacks to Q32.32 fixed point, runs a serial double-dabble over the integer part, then does a serial multiply-by-10 extraction of the fraction digits.
- Results update atomically on completion.

Parameters:
- INT_DIGITS, 10, number of integer BCD digits; legal range 10..12 (10 digits hold 2^32-1).
- FRAC_DIGITS, 6, number of fractional BCD digits; legal range 1..9.

Ports:
- CLK  input  1  system clock; all state on posedge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request conversion of F_IN; sampled only in IDLE.
- F_IN  input  32  IEEE-754 single, captured on the accepted START edge.
- BUSY  output  1  high from the cycle after an accepted START through the DONE cycle inclusive.
- DONE  output  1  one-cycle pulse; outputs valid from this cycle on.
- SIGN  output  1  1 = negative result displayed.
- INT_BCD  output  4*INT_DIGITS  integer digits; least significant digit in bits [3:0].
- FRAC_BCD  output  4*FRAC_DIGITS  fraction digits; first digit after the point in the top nibble.
- SPECIAL  output  2  00 normal, 01 infinity, 10 NaN, 11 out of range (|x| >= 2^32).

Behaviour:
- Reset (RESET=0, any time, including mid-conversion):
  - State goes to IDLE.
  - BUSY, DONE, SIGN, INT_BCD, FRAC_BCD and SPECIAL all clear to 0.
  - The in-flight conversion is discarded.
- States: IDLE -> UNPACK -> DABBLE -> FRAC -> FINISH -> IDLE.
- IDLE:
  - START=1 latches F_IN; next state is UNPACK.
  - START while BUSY is ignored (no queueing).
- UNPACK, 1 cycle. Let e = F_IN[30:23] and m = F_IN[22:0].
  - e=255, m!=0: code NaN, SIGN=0, value 0.
  - e=255, m=0: code inf, SIGN=F_IN[31], value 0.
  - e>=159: code out of range, SIGN=F_IN[31], value 0.
  - e<95 or e=0 (zero, denormals and tiny values flushed): value 0, SIGN=0; -0 displays as +0.
  - Otherwise: value = {1,m} placed so the hidden bit sits at Q32.32 bit 32+(e-127). Bits below bit 0 are truncated. SIGN=F_IN[31]; code normal.
- DABBLE, exactly 32 cycles:
  - Classic shift-add-3 over the upper 32 bits into an INT_DIGITS-digit BCD shadow register.
  - The add-3 correction applies to every digit >=5 before each shift.
- FRAC, exactly FRAC_DIGITS cycles:
  - f = f*10 on 36 bits; digit = f[35:32]; keep f[31:0].
  - Digits fill from most significant. Truncation, no rounding.
- FINISH, 1 cycle:
  - Shadow registers copy to SIGN, INT_BCD, FRAC_BCD and SPECIAL.
  - DONE=1; next state is IDLE.
- Latency is constant for all inputs, including special cases.
  - DONE is high exactly 34+FRAC_DIGITS cycles after the START-sampling edge.
  - A new START may be accepted the cycle after DONE.
- Outputs hold the previous result throughout a conversion; no partial values are ever visible.
- Special codes force all digit outputs to 0.
- F_IN changes after capture have no effect.

Test Plan:
- Reset, then 0x3F800000 -> DONE at cycle 40 (FRAC_DIGITS=6); INT_BCD=0000000001, FRAC_BCD=000000, SIGN=0, SPECIAL=00, BUSY high cycles 1..40.
- 0xC0200000 (-2.5) -> SIGN=1, INT_BCD=0000000002, FRAC_BCD=500000; 0x3DCCCCCD (0.1) -> INT 0, FRAC_BCD=100000 (truncated, not rounded).
- 0x4F7FFFFF -> INT_BCD=4294967040, SPECIAL=00; 0x4F800000 -> SPECIAL=11, all digits 0, SIGN=0; 0xCF800000 -> SPECIAL=11, SIGN=1.
- 0x7F800000 -> SPECIAL=01; 0x7FC00000 -> SPECIAL=10, SIGN=0; 0x80000000 and 0x00000001 -> all zero, SIGN=0; 0x2F800000 (2^-32) -> FRAC_BCD=000000.
- Second START pulsed at cycle 10 of a conversion -> ignored, exactly one DONE; START held high continuously -> back-to-back conversions, DONE every 41 cycles.
- RESET driven low at cycle 20 of a conversion on 0x40490FDB -> outputs 0 immediately (asynchronous), no DONE. After release, the previous output values do not reappear until a new START completes (3.141592 for 0x40490FDB).

Source files
------------

// File: rtl/f32_decimal_formatter.sv
// Float32 to sign + integer/fraction BCD converter for the character LCD path.
// Unpack to Q32.32, serial double-dabble on the integer half, then x10 digit extraction on the fraction.
module f32_dec_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module f32_decimal_formatter #(
  parameter int INT_DIGITS  = 10,
  parameter int FRAC_DIGITS = 6
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [31:0]              F_IN,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     SIGN,
  output logic [4*INT_DIGITS-1:0]  INT_BCD,
  output logic [4*FRAC_DIGITS-1:0] FRAC_BCD,
  output logic [1:0]               SPECIAL
);
  localparam int IW = 4*INT_DIGITS;
  localparam int FW = 4*FRAC_DIGITS;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DABBLE, S_FRAC, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   fin_q, fin_d;
  logic [31:0]   ip_q, ip_d;
  logic [31:0]   fp_q, fp_d;
  logic [IW-1:0] bcd_q, bcd_d;
  logic [FW-1:0] fsh_q, fsh_d;
  logic          ssign_q, ssign_d;
  logic [1:0]    sspc_q, sspc_d;

  logic          busy_q, busy_d, done_q, done_d, sign_q, sign_d;
  logic [IW-1:0] int_q, int_d;
  logic [FW-1:0] frac_q, frac_d;
  logic [1:0]    spc_q, spc_d;

  logic [IW-1:0] adj;
  logic [7:0]    e;
  logic [22:0]   m;
  logic [63:0]   val;
  logic [5:0]    shamt;
  logic [35:0]   prod;

  // add-3 correction per BCD digit, applied before every dabble shift
  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_dig
    f32_dec_add3 u_add3 (.d(bcd_q[4*g +: 4]), .q(adj[4*g +: 4]));
  end

  assign e     = fin_q[30:23];
  assign m     = fin_q[22:0];
  // hidden bit parked at bit 63, then shifted down to Q32.32 bit (e-95)
  assign shamt = 6'(8'd158 - e);
  assign val   = {1'b1, m, 40'b0} >> shamt;
  assign prod  = {1'b0, fp_q, 3'b0} + {3'b0, fp_q, 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    ip_d    = ip_q;
    fp_d    = fp_q;
    bcd_d   = bcd_q;
    fsh_d   = fsh_q;
    ssign_d = ssign_q;
    sspc_d  = sspc_q;
    busy_d  = (state_q != S_IDLE) || START;
    done_d  = 1'b0;
    sign_d  = sign_q;
    int_d   = int_q;
    frac_d  = frac_q;
    spc_d   = spc_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          fin_d   = F_IN;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        bcd_d   = '0;
        fsh_d   = '0;
        cnt_d   = '0;
        ip_d    = '0;
        fp_d    = '0;
        ssign_d = 1'b0;
        sspc_d  = 2'b00;
        if (e == 8'd255 && m != 23'd0) begin
          sspc_d = 2'b10;
        end else if (e == 8'd255) begin
          sspc_d  = 2'b01;
          ssign_d = fin_q[31];
        end else if (e >= 8'd159) begin
          sspc_d  = 2'b11;
          ssign_d = fin_q[31];
        end else if (e >= 8'd95) begin
          ip_d    = val[63:32];
          fp_d    = val[31:0];
          ssign_d = fin_q[31];
        end
        state_d = S_DABBLE;
      end
      S_DABBLE: begin
        bcd_d = IW'({adj, ip_q[31]});
        ip_d  = {ip_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d   = '0;
          state_d = S_FRAC;
        end
      end
      S_FRAC: begin
        fsh_d      = fsh_q << 4;
        fsh_d[3:0] = prod[35:32];
        fp_d       = prod[31:0];
        cnt_d      = cnt_q + 6'd1;
        if (cnt_q == 6'(FRAC_DIGITS-1)) begin
          cnt_d   = '0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        sign_d  = ssign_q;
        int_d   = bcd_q;
        frac_d  = fsh_q;
        spc_d   = sspc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fin_q   <= '0;
      ip_q    <= '0;
      fp_q    <= '0;
      bcd_q   <= '0;
      fsh_q   <= '0;
      ssign_q <= 1'b0;
      sspc_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
      spc_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      ip_q    <= ip_d;
      fp_q    <= fp_d;
      bcd_q   <= bcd_d;
      fsh_q   <= fsh_d;
      ssign_q <= ssign_d;
      sspc_q  <= sspc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      spc_q   <= spc_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign SIGN     = sign_q;
  assign INT_BCD  = int_q;
  assign FRAC_BCD = frac_q;
  assign SPECIAL  = spc_q;
endmodule
